// File: rtl/eop_detector_if.sv
// eop_detector_if: USB line pair and EOP detector status bundle.
// Optional eop_raw signal exists only when EOP_RAW_OUT_EN is defined.
interface eop_detector_if #(
    parameter int CNT_W = 4
);
    logic             d_plus;
    logic             d_minus;
    logic             eop;
    logic             eop_done;
    logic             eop_err;
    logic             se1_err;
    logic [CNT_W-1:0] se0_count;
`ifdef EOP_RAW_OUT_EN
    logic             eop_raw;
`endif

    modport master (
`ifdef EOP_RAW_OUT_EN
        input  eop_raw,
`endif
        output d_plus,
        output d_minus,
        input  eop,
        input  eop_done,
        input  eop_err,
        input  se1_err,
        input  se0_count
    );

    modport slave (
`ifdef EOP_RAW_OUT_EN
        output eop_raw,
`endif
        input  d_plus,
        input  d_minus,
        output eop,
        output eop_done,
        output eop_err,
        output se1_err,
        output se0_count
    );
endinterface

// File: rtl/eop_detector.sv
// eop_detector: USB EOP detector (SE0 run then J) with SE0/K and SE1 errors.
// Define EOP_RAW_OUT_EN to add the unsynchronized combinational eop_raw output.
module eop_detector #(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_SE0_CYCLES = 2,
    parameter int CNT_W          = 4
) (
    input logic           clk,
    input logic           rst,
    eop_detector_if.slave bus
);
    typedef enum logic {IDLE, IN_SE0} state_t;

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_SE0_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] dp_sync;
    logic [SYNC_STAGES-1:0] dm_sync;
    logic                   dp_s;
    logic                   dm_s;
    logic                   se0;
    logic                   j;
    logic                   k;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             eop_q;
    logic             done_q;
    logic             done_n;
    logic             err_q;
    logic             err_n;
    logic             se1_q;
    logic             se1_n;

    // Input synchronizers; reset to idle J so no false SE0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_sync <= '1;
            dm_sync <= '0;
        end else begin
            dp_sync <= {dp_sync[SYNC_STAGES-2:0], bus.d_plus};
            dm_sync <= {dm_sync[SYNC_STAGES-2:0], bus.d_minus};
        end
    end

    assign dp_s = dp_sync[SYNC_STAGES-1];
    assign dm_s = dm_sync[SYNC_STAGES-1];
    assign se0  = ~dp_s & ~dm_s;
    assign j    =  dp_s & ~dm_s;
    assign k    = ~dp_s &  dm_s;

    // Next-state, SE0 run counter and pulse decisions.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        err_n   = 1'b0;
        se1_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (se0) begin
                    state_n = IN_SE0;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n = '0;
                    se1_n = dp_s & dm_s;
                end
            end
            IN_SE0: begin
                state_n = IDLE;
                cnt_n   = '0;
                unique case (1'b1)
                    se0: begin
                        state_n = IN_SE0;
                        cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    end
                    j: begin
                        done_n = (cnt >= MIN_C);
                        err_n  = (cnt <  MIN_C);
                    end
                    k: begin
                        err_n = 1'b1;
                    end
                    default: begin
                        se1_n = 1'b1;
                        err_n = 1'b1;
                    end
                endcase
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            eop_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            se1_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            eop_q  <= se0;
            done_q <= done_n;
            err_q  <= err_n;
            se1_q  <= se1_n;
        end
    end

    assign bus.eop       = eop_q;
    assign bus.eop_done  = done_q;
    assign bus.eop_err   = err_q;
    assign bus.se1_err   = se1_q;
    assign bus.se0_count = cnt;

`ifdef EOP_RAW_OUT_EN
    assign bus.eop_raw = ~bus.d_plus & ~bus.d_minus;
`endif
endmodule

// File: tb/tb_eop_detector.sv
// tb_eop_detector: directed vectors for eop_detector at default parameters.
// Outputs reflect the pins applied two steps earlier (sync + output register).
module tb_eop_detector;
    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    eop_detector_if #(.CNT_W(4)) bus ();

    eop_detector #(
        .SYNC_STAGES   (2),
        .MIN_SE0_CYCLES(2),
        .CNT_W         (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e, input logic d,
                             input logic er, input logic s1, input int cnt);
        check({tag, ".eop"},  32'(bus.eop), 32'(e));
        check({tag, ".done"}, 32'(bus.eop_done), 32'(d));
        check({tag, ".err"},  32'(bus.eop_err), 32'(er));
        check({tag, ".se1"},  32'(bus.se1_err), 32'(s1));
        check({tag, ".cnt"},  32'(bus.se0_count), 32'(cnt));
    endtask

    // Drive pins just after a falling edge, check at the next falling edge.
    task automatic step(input string tag, input logic dp, input logic dm,
                        input logic e, input logic d, input logic er,
                        input logic s1, input int cnt);
        bus.d_plus  = dp;
        bus.d_minus = dm;
        @(negedge clk);
        check_all(tag, e, d, er, s1, cnt);
    endtask

    // Expected outputs per sampled symbol in the 00,01,10,11 loop.
    logic sym_eop [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic sym_err [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic sym_se1 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int   sym_cnt [4] = '{1, 0, 0, 0};

    initial begin
        n_run       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.d_plus  = 1'b1;
        bus.d_minus = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            step($sformatf("idle_j%0d", i), 1'b1, 1'b0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            logic [1:0] sym;
            int         s;
            sym = 2'(i % 4);
            if (i >= 16) sym = 2'b10;
            if (i < 2) begin
                step($sformatf("loop%0d", i), sym[1], sym[0], 0, 0, 0, 0, 0);
            end else begin
                s = (i - 2) % 4;
                step($sformatf("loop%0d", i), sym[1], sym[0],
                     sym_eop[s], 1'b0, sym_err[s], sym_se1[s], sym_cnt[s]);
            end
        end

        step("se0x3_0", 1'b0, 1'b0, 0, 0, 0, 0, 0);
        step("se0x3_1", 1'b0, 1'b0, 0, 0, 0, 0, 0);
        step("se0x3_2", 1'b0, 1'b0, 1, 0, 0, 0, 1);
        step("se0x3_3", 1'b1, 1'b0, 1, 0, 0, 0, 2);
        step("se0x3_4", 1'b1, 1'b0, 1, 0, 0, 0, 3);
        step("se0x3_5", 1'b1, 1'b0, 0, 1, 0, 0, 0);
        step("se0x3_6", 1'b1, 1'b0, 0, 0, 0, 0, 0);
        step("se0x3_7", 1'b1, 1'b0, 0, 0, 0, 0, 0);

        step("se0k_0", 1'b0, 1'b0, 0, 0, 0, 0, 0);
        step("se0k_1", 1'b0, 1'b0, 0, 0, 0, 0, 0);
        step("se0k_2", 1'b0, 1'b1, 1, 0, 0, 0, 1);
        step("se0k_3", 1'b1, 1'b0, 1, 0, 0, 0, 2);
        step("se0k_4", 1'b1, 1'b0, 0, 0, 1, 0, 0);
        step("se0k_5", 1'b1, 1'b0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic lj;
            lj = (i >= 20);
            if (i < 2 || i == 23)
                step($sformatf("sat%0d", i), lj, 1'b0, 0, 0, 0, 0, 0);
            else if (i == 22)
                step($sformatf("sat%0d", i), lj, 1'b0, 0, 1, 0, 0, 0);
            else
                step($sformatf("sat%0d", i), lj, 1'b0, 1, 0, 0, 0,
                     (i - 1 > 15) ? 15 : i - 1);
        end

        step("rstse0_0", 1'b0, 1'b0, 0, 0, 0, 0, 0);
        step("rstse0_1", 1'b0, 1'b0, 0, 0, 0, 0, 0);
        step("rstse0_2", 1'b0, 1'b0, 1, 0, 0, 0, 1);
        step("rstse0_3", 1'b0, 1'b0, 1, 0, 0, 0, 2);
        step("rstse0_4", 1'b0, 1'b0, 1, 0, 0, 0, 3);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
`ifdef EOP_RAW_OUT_EN
        check("raw_se0", 32'(bus.eop_raw), 32'd1);
        bus.d_plus = 1'b1;
        #1;
        check("raw_j", 32'(bus.eop_raw), 32'd0);
        bus.d_plus  = 1'b0;
        bus.d_minus = 1'b1;
        #1;
        check("raw_k", 32'(bus.eop_raw), 32'd0);
`endif
        bus.d_plus  = 1'b1;
        bus.d_minus = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++)
            step($sformatf("post_rst%0d", i), 1'b1, 1'b0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/eop_detector.md
Name: eop_detector

Overview:
- USB end-of-packet detector sitting behind the D+/D− line receiver and ahead of the packet decoder.
- Synchronizes the raw bus pair and flags the single-ended-zero (SE0) condition (D+ = 0, D− = 0).
- Qualifies a full EOP as SE0 held for a minimum duration followed by return to J (D+ = 1, D− = 0).
- Flags SE1 and SE0→K protocol errors.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer chain (legal 2..4).
- MIN_SE0_CYCLES, 2, minimum consecutive synchronized SE0 cycles for a valid EOP (legal 1..2^CNT_W−1).
- CNT_W, 4, width of the SE0 duration counter.

Ports:
- clk, input, 1, system clock, all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- d_plus, input, 1, raw D+ line, asynchronous to clk.
- d_minus, input, 1, raw D− line, asynchronous to clk.
- eop, output, 1, registered SE0 level on synchronized lines.
- eop_done, output, 1, one-cycle pulse: qualified EOP completed (SE0 ≥ MIN_SE0_CYCLES then J).
- eop_err, output, 1, one-cycle pulse: SE0 ended in K, or SE0 shorter than MIN_SE0_CYCLES.
- se1_err, output, 1, one-cycle pulse on each cycle synchronized lines show SE1 (1,1).
- se0_count, output, CNT_W, current SE0 run length, saturating.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports named clk and rst.
- Reset: D+ sync chain → 1, D− chain → 0 (idle J). eop, eop_done, eop_err, se1_err → 0; se0_count → 0; FSM → IDLE. Reset asserted mid-SE0 aborts with no pulse.
- Sync: dp_s/dm_s = last stage of each SYNC_STAGES-deep chain.
- eop <= ~dp_s & ~dm_s. Input-to-eop latency is SYNC_STAGES+1 clocks (3 at default). eop deasserts with the same latency.
- Line decode on (dp_s, dm_s): 00 = SE0, 10 = J, 01 = K, 11 = SE1.
- FSM IDLE:
  - SE0 → go to IN_SE0, se0_count <= 1.
  - SE1 → se1_err pulse.
  - Otherwise stay, se0_count <= 0.
- FSM IN_SE0:
  - SE0 → se0_count increments, saturating at 2^CNT_W−1, never wraps.
  - J with se0_count ≥ MIN_SE0_CYCLES → eop_done pulse, IDLE.
  - J with se0_count < MIN_SE0_CYCLES → eop_err pulse, IDLE.
  - K → eop_err pulse, IDLE.
  - SE1 → se1_err and eop_err in the same cycle, IDLE.
  - On every exit, se0_count <= 0.
- All pulse outputs are registered, exactly one cycle wide, and asserted the cycle after the decision state is sampled.
- Back-to-back: SE0 directly after eop_done re-enters IN_SE0 on the next SE0 sample.

Optional Feature:
- Macro: EOP_RAW_OUT_EN.
- Defined: adds output eop_raw (1 bit) = ~d_plus & ~d_minus, purely combinational on the unsynchronized pins. Zero latency; not gated by rst.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Reset with lines at (1,0): eop=0, se0_count=0, no pulses; release, hold J 10 cycles → outputs stay 0.
- Sequence 00,01,10,11, each held 1 cycle, repeated 4 times → eop high exactly 1 cycle per loop at 3-cycle latency. Each 1-cycle SE0 → eop_err, with MIN=2 and the following sample K. Each 11 → se1_err.
- SE0 held 3 cycles then J → se0_count reaches 3, eop_done single pulse, eop_err=0, eop falls 3 cycles after J.
- SE0 held 2 cycles then K → eop_err pulse, no eop_done, FSM returns to IDLE.
- SE0 held 20 cycles with CNT_W=4 → se0_count saturates at 15. Then J → eop_done.
- Assert rst during a 5-cycle SE0 → all outputs 0 immediately (asynchronous); no pulse after release. With EOP_RAW_OUT_EN, eop_raw follows 00 on pins with no clock delay.
